// File: rtl/fini_ctrl_pkg.sv
// Shared definitions for the time-redundant AND controller: state
// encoding, width-generic rotate helpers, bitwise majority vote and the
// default fault-counter width.
package fini_ctrl_pkg;

   localparam int FINI_CNT_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PASS1 = 3'd1,
      ST_PASS2 = 3'd2,
      ST_PASS3 = 3'd3,
      ST_DONE  = 3'd4
   } fini_state_e;

   // Rotate the low w bits of x left by n (bit i -> bit (i+n) mod w).
   // Bits at or above w are returned as zero. Callers pass a constant w.
   function automatic logic [31:0] fini_rotl(input logic [31:0] x,
                                             input int          n,
                                             input int          w);
      logic [31:0] res;
      logic [4:0]  src;
      logic [4:0]  dst;
      int          sh;
      res = 32'd0;
      sh  = n % w;
      for (int i = 0; i < 32; i++) begin
         src = 5'(i);
         dst = 5'((i + sh) % w);
         res[dst] = (i < w) ? x[src] : res[dst];
      end
      return res;
   endfunction

   // Rotate the low w bits of x right by n.
   function automatic logic [31:0] fini_rotr(input logic [31:0] x,
                                             input int          n,
                                             input int          w);
      return fini_rotl(x, w - (n % w), w);
   endfunction

   // Bitwise 2-of-3 vote.
   function automatic logic [31:0] fini_maj3(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/fini_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module fini_sat_cnt
   import fini_ctrl_pkg::*;
#(
   parameter int CNT_W = FINI_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_cnt;

   // Count events, hold at all-ones, clear on request or reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (clr) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (inc && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/fini_and_tr_ctrl.sv
// Time-redundant sequencer for one shared AND datapath. Each operand pair
// is evaluated twice, the second time on operands rotated by one lane, so
// a lane-local fault corrupts different logical bits in each pass. On a
// mismatch the result is zeroized and a saturating fault counter bumps.
// Optional build macro FINI_AND_MAJORITY_EN adds a third pass rotated by
// two lanes and replaces zeroization with a bitwise majority vote (needs
// WIDTH >= 3).
module fini_and_tr_ctrl
   import fini_ctrl_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int CNT_W = FINI_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] dp_a,
   output logic [WIDTH-1:0] dp_b,
   input  logic [WIDTH-1:0] dp_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_c,
   output logic             out_fault,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] fault_cnt
);

   localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
   localparam logic [2:0] S_PASS1 = 3'(ST_PASS1);
   localparam logic [2:0] S_PASS2 = 3'(ST_PASS2);
   localparam logic [2:0] S_PASS3 = 3'(ST_PASS3);
   localparam logic [2:0] S_DONE  = 3'(ST_DONE);

   logic [2:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_r1;
   logic [WIDTH-1:0] r_out_c;
   logic             r_out_fault;

   logic [WIDTH-1:0] w_r2;
   logic             w_mismatch;
   logic             w_fault_inc;
`ifdef FINI_AND_MAJORITY_EN
   logic [WIDTH-1:0] r_r2;
   logic [WIDTH-1:0] w_r3;
   logic [WIDTH-1:0] w_vote;
`endif

   // Undo each pass's rotation so results line up with logical bits.
   assign w_r2 = WIDTH'(fini_rotr(32'(dp_c), 1, WIDTH));
`ifdef FINI_AND_MAJORITY_EN
   assign w_r3       = WIDTH'(fini_rotr(32'(dp_c), 2, WIDTH));
   assign w_vote     = WIDTH'(fini_maj3(32'(r_r1), 32'(r_r2), 32'(w_r3)));
   assign w_mismatch = (r_r1 != r_r2) || (r_r1 != w_r3) || (r_r2 != w_r3);
   assign w_fault_inc = (r_state == S_PASS3) && w_mismatch;
`else
   assign w_mismatch  = (r_r1 != w_r2);
   assign w_fault_inc = (r_state == S_PASS2) && w_mismatch;
`endif

   // Drive the shared datapath only during pass states; zero otherwise so
   // no operand leaks onto the datapath while idle or holding a result.
   always_comb begin
      dp_a = {WIDTH{1'b0}};
      dp_b = {WIDTH{1'b0}};
      case (r_state)
         S_PASS1: begin
            dp_a = r_a;
            dp_b = r_b;
         end
         S_PASS2: begin
            dp_a = WIDTH'(fini_rotl(32'(r_a), 1, WIDTH));
            dp_b = WIDTH'(fini_rotl(32'(r_b), 1, WIDTH));
         end
         S_PASS3: begin
`ifdef FINI_AND_MAJORITY_EN
            dp_a = WIDTH'(fini_rotl(32'(r_a), 2, WIDTH));
            dp_b = WIDTH'(fini_rotl(32'(r_b), 2, WIDTH));
`else
            dp_a = {WIDTH{1'b0}};
            dp_b = {WIDTH{1'b0}};
`endif
         end
         default: begin
            dp_a = {WIDTH{1'b0}};
            dp_b = {WIDTH{1'b0}};
         end
      endcase
   end

   // Sequencer: capture operands, collect pass results, register verdict.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= {WIDTH{1'b0}};
         r_b         <= {WIDTH{1'b0}};
         r_r1        <= {WIDTH{1'b0}};
         r_out_c     <= {WIDTH{1'b0}};
         r_out_fault <= 1'b0;
`ifdef FINI_AND_MAJORITY_EN
         r_r2        <= {WIDTH{1'b0}};
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_state <= S_PASS1;
               end
            end
            S_PASS1: begin
               r_r1    <= dp_c;
               r_state <= S_PASS2;
            end
            S_PASS2: begin
`ifdef FINI_AND_MAJORITY_EN
               r_r2    <= w_r2;
               r_state <= S_PASS3;
`else
               r_out_c     <= w_mismatch ? {WIDTH{1'b0}} : r_r1;
               r_out_fault <= w_mismatch;
               r_state     <= S_DONE;
`endif
            end
            S_PASS3: begin
`ifdef FINI_AND_MAJORITY_EN
               r_out_c     <= w_vote;
               r_out_fault <= w_mismatch;
               r_state     <= S_DONE;
`else
               r_state <= S_IDLE;
`endif
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   fini_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_fault_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_fault_inc),
      .clr   (cnt_clr),
      .cnt   (fault_cnt)
   );

   // in_ready also drops while reset is held so nothing is accepted then.
   assign in_ready  = rst_n && (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign out_c     = r_out_c;
   assign out_fault = r_out_fault;

endmodule

// File: tb/tb_fini_and_tr_ctrl.sv
// Self-checking bench for fini_and_tr_ctrl with a behavioural datapath
// (AND plus injectable stuck-at lanes) and a spec-level reference model.
module tb_fini_and_tr_ctrl;

   localparam int W     = 5;
   localparam int CW    = 8;
   localparam int CMAX  = 255;
`ifdef FINI_AND_MAJORITY_EN
   localparam int NP = 3;
`else
   localparam int NP = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic [W-1:0]  dp_a;
   logic [W-1:0]  dp_b;
   logic [W-1:0]  dp_c;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_c;
   logic          out_fault;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] fault_cnt;

   logic [W-1:0]  s1 = '0;   // stuck-at-1 lanes
   logic [W-1:0]  s0 = '0;   // stuck-at-0 lanes

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   assign dp_c = ((dp_a & dp_b) | s1) & ~s0;

   fini_and_tr_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
      .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
      .out_fault(out_fault), .cnt_clr(cnt_clr), .fault_cnt(fault_cnt)
   );

   function automatic logic [W-1:0] ref_rotl(input logic [W-1:0] x, input int n);
      int k;
      k = n % W;
      if (k == 0) return x;
      return (x << k) | (x >> (W - k));
   endfunction

   function automatic logic [W-1:0] ref_rotr(input logic [W-1:0] x, input int n);
      return ref_rotl(x, W - (n % W));
   endfunction

   // Result of pass p as seen in logical bit order.
   function automatic logic [W-1:0] ref_pass(input logic [W-1:0] a, input logic [W-1:0] b, input int p);
      logic [W-1:0] lane;
      lane = ((ref_rotl(a, p) & ref_rotl(b, p)) | s1) & ~s0;
      return ref_rotr(lane, p);
   endfunction

   // Drives one operation and checks every cycle of it against the model.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit clr_final);
      logic [W-1:0] r [3];
      logic [W-1:0] exp_c;
      logic         exp_f;
      int           n;
      int           ones;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_wait: in_ready=%b required 1", in_ready);
      end
      for (int p = 0; p < 3; p++) r[p] = ref_pass(a, b, p);
      exp_f = (r[0] != r[1]);
      if (NP == 3) exp_f = exp_f || (r[0] != r[2]) || (r[1] != r[2]);
      if (NP == 3) begin
         for (int i = 0; i < W; i++) begin
            ones = int'(r[0][i]) + int'(r[1][i]) + int'(r[2][i]);
            exp_c[i] = (ones >= 2);
         end
      end else begin
         exp_c = exp_f ? '0 : r[0];
      end
      in_valid = 1'b1; in_a = a; in_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
      for (int p = 0; p < NP; p++) begin
         @(negedge clk);
         checks++;
         if (dp_a !== ref_rotl(a, p) || dp_b !== ref_rotl(b, p)) begin
            errors++;
            $display("FAIL pass%0d_dp: dp_a=%b dp_b=%b required %b %b", p + 1, dp_a, dp_b, ref_rotl(a, p), ref_rotl(b, p));
         end
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pass%0d_hs: out_valid=%b in_ready=%b required 0 0", p + 1, out_valid, in_ready);
         end
         if (p == NP - 1) cnt_clr = clr_final;
         @(posedge clk); #1;
         cnt_clr = 1'b0;
      end
      if (clr_final) exp_cnt = 0;
      else if (exp_f && exp_cnt < CMAX) exp_cnt = exp_cnt + 1;
      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_hs: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
         end
         checks++;
         if (out_c !== exp_c || out_fault !== exp_f) begin
            errors++;
            $display("FAIL result: out_c=%b out_fault=%b required %b %b", out_c, out_fault, exp_c, exp_f);
         end
         checks++;
         if (fault_cnt !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL fault_cnt: got %0d required %0d", fault_cnt, exp_cnt);
         end
         checks++;
         if (dp_a !== '0 || dp_b !== '0) begin
            errors++;
            $display("FAIL done_dp: dp_a=%b dp_b=%b required 0 0", dp_a, dp_b);
         end
         if (hold > 0) begin
            in_valid = (h % 2 == 0) ? 1'b1 : 1'b0;
            in_a = '1; in_b = '1;
         end
         out_ready = (h == hold);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || dp_a !== '0) begin
         errors++;
         $display("FAIL back_idle: out_valid=%b in_ready=%b dp_a=%b required 0 1 0", out_valid, in_ready, dp_a);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_fault !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: in_ready=%b out_valid=%b out_fault=%b required 0 0 0", in_ready, out_valid, out_fault);
      end
      checks++;
      if (dp_a !== '0 || dp_b !== '0 || out_c !== '0 || fault_cnt !== '0) begin
         errors++;
         $display("FAIL reset_data: dp_a=%b dp_b=%b out_c=%b cnt=%0d required 0", dp_a, dp_b, out_c, fault_cnt);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b required 1", in_ready);
      end
      exp_cnt = 0;
   endtask

   task automatic test_fault_free();
      s1 = '0; s0 = '0;
      do_op(5'b10110, 5'b11100, 0, 1'b0);
      do_op(5'b11111, 5'b10101, 0, 1'b0);
   endtask

   task automatic test_stuck_lane();
      s1 = 5'b00001; s0 = '0;
      do_op(5'b00000, 5'b00000, 0, 1'b0);
      s1 = '0; s0 = 5'b00100;
      do_op(5'b11111, 5'b11111, 0, 1'b0);
      s0 = '0;
   endtask

   task automatic test_backpressure();
      s1 = '0; s0 = '0;
      do_op(5'b01101, 5'b11011, 4, 1'b0);
      do_op(5'b11111, 5'b11111, 0, 1'b0);
   endtask

   task automatic test_mid_reset();
      s1 = 5'b00001;
      do_op(5'b00000, 5'b00000, 0, 1'b0);
      in_valid = 1'b1; in_a = 5'b10101; in_b = 5'b01111;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_cnt = 0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || dp_a !== '0 || dp_b !== '0 || fault_cnt !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: out_valid=%b dp_a=%b dp_b=%b cnt=%0d in_ready=%b required 0 0 0 0 1", out_valid, dp_a, dp_b, fault_cnt, in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: out_valid=%b required 0", out_valid);
         end
      end
      s1 = '0;
   endtask

   task automatic test_saturate();
      s1 = 5'b00001; s0 = '0;
      for (int i = 0; i < 260; i++) do_op(5'b00000, 5'b00000, 0, 1'b0);
      checks++;
      if (fault_cnt !== 8'd255) begin
         errors++;
         $display("FAIL saturate: fault_cnt=%0d required 255", fault_cnt);
      end
      do_op(5'b00000, 5'b00000, 0, 1'b1);
      do_op(5'b00000, 5'b00000, 0, 1'b0);
      s1 = '0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         s1 = ($urandom_range(0, 2) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
         s0 = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
         do_op(W'($urandom), W'($urandom), $urandom_range(0, 2), ($urandom_range(0, 9) == 0));
      end
      s1 = '0; s0 = '0;
   endtask

   initial begin
      test_reset();
      test_fault_free();
      test_stuck_lane();
      test_backpressure();
      test_mid_reset();
      test_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
